mvm_stream_engine: RTL and testbench
====================================

Name: mvm_stream_engine

Overview:
- Parametrised successor to the fixed 3x3 matrix-vector datapath.
- Generalised to an NxN signed matrix times an N-element vector, with configurable data and output widths.
- Owns its x/a/y storage and control FSM internally, so no external address or write-enable sequencing is needed.
- Input uses a valid/ready stream carrying the matrix (row-major), then the vector. Results leave on a valid/ready stream.

Parameters:
N, 3, matrix dimension (N>=1); matrix holds N*N elements, vector holds N
DW, 8, signed element width of matrix and vector entries
OW, 16, signed result width presented on m_data

Ports:
clk  in  1  rising-edge clock
reset  in  1  asynchronous, active-high reset
s_valid  in  1  input element valid
s_ready  out  1  engine accepts an input element
s_data  in  DW  signed input element (matrix row-major, then vector)
m_valid  out  1  result valid
m_ready  in  1  downstream accepts result
m_data  out  OW  signed result y[k]
busy  out  1  high in COMPUTE or OUTPUT

Behaviour:
- Clocking and reset:
  - One clock (clk). Reset is asynchronous, active-high (reset).
  - Reset values: state=LOAD_M, all counters 0, y registers 0, accumulator 0, m_valid=0, m_data=0, busy=0.
  - s_ready=0 while reset is asserted, and 1 from the first clock edge after deassertion.
- Handshakes:
  - An input transfer occurs on an edge with s_valid&&s_ready. An output transfer occurs on an edge with m_valid&&m_ready.
  - s_valid while s_ready=0 is ignored. No data is consumed.
- State machine:
  - LOAD_M: s_ready=1. Each transfer writes a[r][c]; c increments and wraps at N-1 into r+1. After transfer number N*N the state moves to LOAD_X and the counters clear.
  - LOAD_X: s_ready=1. Each transfer writes x[i]. After transfer number N the state moves to COMPUTE.
  - COMPUTE: s_ready=0, busy=1. One MAC per clock, row r, column c, acc <= acc + a[r][c]*x[c].
    - Accumulator clears implicitly at c=0 (acc <= product).
    - At c=N-1, y[r] is written with the converted sum acc+product in the same edge.
    - Exactly N*N clocks. If the last x is accepted at edge E, the state becomes OUTPUT at edge E+N*N.
  - OUTPUT: m_valid=1, m_data=y[k] with k starting at 0. k advances on each output transfer.
    - The transfer of y[N-1] returns the state to LOAD_M, with m_valid=0 and busy=0 after that edge.
- Output stability: m_data and m_valid hold stable while m_valid&&!m_ready (backpressure of any length).
- Arithmetic:
  - Products are full 2*DW signed.
  - Accumulator is AW = 2*DW + clog2(N) signed bits (minimum 2*DW when N=1). It never overflows internally.
  - Conversion to OW is defined under Optional Feature.
- Boundary conditions:
  - N=1: LOAD_M takes 1 element, COMPUTE takes 1 clock, 1 result.
  - Reset asserted in any state aborts immediately. Partially loaded data is discarded and the next stream starts at a[0][0].
  - Input arriving during COMPUTE or OUTPUT is stalled, never dropped or reordered.
  - There is no overlap between output of one job and loading of the next.

Optional Feature:
- Macro: MVM_SAT_EN.
- When defined: the AW-bit sum is saturated to the signed OW range, [-2^(OW-1), 2^(OW-1)-1].
- When undefined: the low OW bits are taken (two's-complement wrap).
- Storage, timing and handshakes are identical in both builds.

Test Plan:
- Identity 3x3, x=[5,-3,7], m_ready=1
  -> y=[5,-3,7].
  -> m_valid first high exactly 9 clocks after the last x transfer.
  -> busy drops after the third output.
- All a=127, all x=127
  -> sum 48387 per row.
  -> without MVM_SAT_EN, m_data=-17149 x3.
  -> with MVM_SAT_EN, m_data=32767 x3.
- Row0 all -128, rows 1-2 all 0, x=[127,127,127]
  -> sum -48768.
  -> wrap build: y=[16768,0,0].
  -> sat build: y=[-32768,0,0].
- Matrix 1..9 row-major, x=[1,2,3], m_ready low for 5 clocks while y[1] presented
  -> y=[14,32,50].
  -> m_data holds 32 during the stall.
  -> s_ready stays 0 until y[2] is accepted.
- Reset pulsed after 9 matrix elements and 2 x elements, then a fresh stream of the matrix 1..9 with x=[1,0,-1]
  -> y=[-2,-2,-2].
  -> No leftover state from the aborted job.
- Random s_valid bubbles (about 50%) and random m_ready over 20 back-to-back jobs
  -> results match the reference model.
  -> No lost or duplicated transfers.

Source files
------------

// File: rtl/mvm_stream_engine.sv
// mvm_stream_engine: streamed NxN signed matrix times N-vector; saturating output when MVM_SAT_EN is defined, wrapping otherwise
module mvm_stream_engine #(
  parameter int N  = 3,
  parameter int DW = 8,
  parameter int OW = 16
) (
  input  logic                 clk,
  input  logic                 reset,
  input  logic                 s_valid,
  output logic                 s_ready,
  input  logic signed [DW-1:0] s_data,
  output logic                 m_valid,
  input  logic                 m_ready,
  output logic signed [OW-1:0] m_data,
  output logic                 busy
);
  localparam int AW = 2*DW + $clog2(N);
  localparam int RW = N > 1 ? $clog2(N) : 1;
  localparam int CW = N > 1 ? $clog2(N*N) : 1;
  typedef enum logic [1:0] {LOAD_M, LOAD_X, COMPUTE, OUTPUT} state_t;
  state_t state, state_nx;
  logic live;
  logic [CW-1:0] cnt;
  logic [RW-1:0] r, c;
  logic signed [DW-1:0] a [N*N];
  logic signed [DW-1:0] x [N];
  logic signed [OW-1:0] y [N];
  logic signed [AW-1:0] acc, sum, prod_w;
  logic signed [2*DW-1:0] prod;
  logic signed [OW-1:0] conv;
  logic in_xfer, out_xfer, last_m, last_n, last_c;
  assign s_ready  = live && (state == LOAD_M || state == LOAD_X);
  assign m_valid  = state == OUTPUT;
  assign busy     = state == COMPUTE || state == OUTPUT;
  assign m_data   = y[cnt[RW-1:0]];
  assign in_xfer  = s_valid && s_ready;
  assign out_xfer = m_valid && m_ready;
  assign last_m   = cnt == CW'(N*N-1);
  assign last_n   = cnt == CW'(N-1);
  assign last_c   = c == RW'(N-1);
  // During COMPUTE cnt walks the row-major matrix index while c selects the vector element
  assign prod   = a[cnt] * x[c];
  assign prod_w = prod;
  assign sum    = (c == '0 ? '0 : acc) + prod_w;
`ifdef MVM_SAT_EN
  localparam int SW = (AW > OW ? AW : OW) + 1;
  localparam logic signed [SW-1:0] MAXV = {{(SW-OW+1){1'b0}}, {(OW-1){1'b1}}};
  localparam logic signed [SW-1:0] MINV = {{(SW-OW+1){1'b1}}, {(OW-1){1'b0}}};
  logic signed [SW-1:0] wide;
  assign wide = sum;
  assign conv = wide > MAXV ? MAXV[OW-1:0] : wide < MINV ? MINV[OW-1:0] : wide[OW-1:0];
`else
  assign conv = OW'(sum);
`endif
  // Next-state: each phase ends on its final transfer or final MAC
  always_comb begin
    state_nx = state;
    if (state == LOAD_M && in_xfer && last_m) state_nx = LOAD_X;
    if (state == LOAD_X && in_xfer && last_n) state_nx = COMPUTE;
    if (state == COMPUTE && last_m) state_nx = OUTPUT;
    if (state == OUTPUT && out_xfer && last_n) state_nx = LOAD_M;
  end
  // Control state, counters, accumulator and result registers
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state <= LOAD_M;
      live  <= 1'b0;
      cnt   <= '0;
      r     <= '0;
      c     <= '0;
      acc   <= '0;
      for (int j = 0; j < N; j++) y[j] <= '0;
    end else begin
      live  <= 1'b1;
      state <= state_nx;
      cnt   <= state_nx != state ? '0 : (in_xfer || out_xfer || state == COMPUTE) ? cnt + 1'b1 : cnt;
      if (state == COMPUTE) begin
        acc <= sum;
        c   <= last_c ? '0 : c + 1'b1;
        r   <= last_m ? '0 : last_c ? r + 1'b1 : r;
        if (last_c) y[r] <= conv;
      end
    end
  end
  // Operand storage needs no reset: every job overwrites it before use
  always_ff @(posedge clk) begin
    if (in_xfer && state == LOAD_M) a[cnt] <= s_data;
    if (in_xfer && state == LOAD_X) x[cnt[RW-1:0]] <= s_data;
  end
endmodule

// File: tb/tb_mvm_stream_engine.sv
// tb_mvm_stream_engine: scoreboard bench with random stimulus against an arithmetic reference model
module tb_mvm_stream_engine;
  localparam int N  = 3;
  localparam int DW = 8;
  localparam int OW = 16;
  localparam int MAXO = (1 << (OW-1)) - 1;
  localparam int MINO = -(1 << (OW-1));
  logic clk = 0;
  logic reset = 1;
  logic s_valid = 0;
  logic s_ready;
  logic signed [DW-1:0] s_data = '0;
  logic m_valid;
  logic m_ready = 0;
  logic signed [OW-1:0] m_data;
  logic busy;
  int errors = 0;
  int checks = 0;
  int am [N*N];
  int xv [N];
  int ym [N];
  int exp_q [$];
  bit rand_rdy = 0;
  mvm_stream_engine #(.N(N), .DW(DW), .OW(OW)) dut (
    .clk(clk), .reset(reset), .s_valid(s_valid), .s_ready(s_ready), .s_data(s_data),
    .m_valid(m_valid), .m_ready(m_ready), .m_data(m_data), .busy(busy)
  );
  always #5 clk = ~clk;
  task automatic check(input string nm, input int act, input int exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0d expected %0d", nm, act, exp);
    end
  endtask
  function automatic int conv(input int s);
    logic signed [OW-1:0] t;
    t = s[OW-1:0];
`ifdef MVM_SAT_EN
    return s > MAXO ? MAXO : s < MINO ? MINO : s;
`else
    return int'(t);
`endif
  endfunction
  function automatic void model();
    for (int i = 0; i < N; i++) begin
      int s = 0;
      for (int j = 0; j < N; j++) s += am[i*N+j] * xv[j];
      ym[i] = conv(s);
      exp_q.push_back(ym[i]);
    end
  endfunction
  // Monitor: every output transfer is compared with the oldest expected result
  always @(negedge clk) begin
    if (!reset && m_valid && m_ready) begin
      if (exp_q.size() == 0) check("unexpected_output", int'(m_data), 99999);
      else check("m_data", int'(m_data), exp_q.pop_front());
    end
  end
  // Random backpressure when enabled
  initial forever begin
    @(posedge clk);
    #1;
    if (rand_rdy) m_ready = 1'($urandom_range(1, 0));
  end
  task automatic send(input int d, input bit bubbles);
    int t = 0;
    if (bubbles) while ($urandom_range(1, 0) == 1) begin
      s_valid = 0;
      @(posedge clk);
      #1;
    end
    s_valid = 1;
    s_data = DW'(d);
    while (!s_ready && t < 2000) begin
      @(posedge clk);
      #1;
      t++;
    end
    if (t >= 2000) check("s_ready_timeout", 0, 1);
    @(posedge clk);
    #1;
    s_valid = 0;
  endtask
  task automatic send_job(input bit bubbles);
    model();
    for (int j = 0; j < N*N; j++) send(am[j], bubbles);
    for (int j = 0; j < N; j++) send(xv[j], bubbles);
  endtask
  task automatic drain(input string nm);
    int t = 0;
    while (exp_q.size() != 0 && t < 5000) begin
      @(posedge clk);
      #1;
      t++;
    end
    check(nm, exp_q.size(), 0);
  endtask
  initial begin
    repeat (2) @(posedge clk);
    #1;
    check("rst_s_ready", int'(s_ready), 0);
    check("rst_m_valid", int'(m_valid), 0);
    check("rst_busy", int'(busy), 0);
    check("rst_m_data", int'(m_data), 0);
    reset = 0;
    check("s_ready_before_edge", int'(s_ready), 0);
    @(posedge clk);
    #1;
    check("s_ready_after_edge", int'(s_ready), 1);
    m_ready = 1;
    for (int j = 0; j < N*N; j++) am[j] = (j / N == j % N) ? 1 : 0;
    xv = '{5, -3, 7};
    send_job(0);
    for (int t = 1; t <= N*N; t++) begin
      @(posedge clk);
      #1;
      if (t == N*N-1) check("latency_early", int'(m_valid), 0);
      if (t == N*N) check("latency_valid", int'(m_valid), 1);
    end
    drain("identity_drain");
    check("busy_after_job", int'(busy), 0);
    check("m_valid_after_job", int'(m_valid), 0);
    for (int j = 0; j < N*N; j++) am[j] = 127;
    xv = '{127, 127, 127};
    send_job(0);
    drain("max_drain");
    for (int j = 0; j < N*N; j++) am[j] = j < N ? -128 : 0;
    send_job(0);
    drain("min_drain");
    for (int j = 0; j < N*N; j++) am[j] = j + 1;
    xv = '{1, 2, 3};
    m_ready = 0;
    send_job(0);
    begin
      int t = 0;
      while (!m_valid && t < 100) begin
        @(posedge clk);
        #1;
        t++;
      end
    end
    check("stall_wait_valid", int'(m_valid), 1);
    m_ready = 1;
    @(posedge clk);
    #1;
    m_ready = 0;
    for (int t = 0; t < 5; t++) begin
      check("stall_m_valid", int'(m_valid), 1);
      check("stall_m_data", int'(m_data), ym[1]);
      check("stall_s_ready", int'(s_ready), 0);
      @(posedge clk);
      #1;
    end
    m_ready = 1;
    @(posedge clk);
    #1;
    check("s_ready_before_last", int'(s_ready), 0);
    @(posedge clk);
    #1;
    check("s_ready_after_last", int'(s_ready), 1);
    check("stall_queue", exp_q.size(), 0);
    for (int j = 0; j < N*N; j++) send(j + 1, 0);
    send(1, 0);
    send(2, 0);
    reset = 1;
    #2;
    check("abort_s_ready", int'(s_ready), 0);
    check("abort_busy", int'(busy), 0);
    reset = 0;
    @(posedge clk);
    #1;
    for (int j = 0; j < N*N; j++) am[j] = j + 1;
    xv = '{1, 0, -1};
    send_job(0);
    drain("abort_drain");
    rand_rdy = 1;
    for (int k = 0; k < 20; k++) begin
      for (int j = 0; j < N*N; j++) am[j] = k % 5 == 0 ? (($urandom_range(1, 0) == 1) ? 127 : -128) : int'($urandom_range(255, 0)) - 128;
      for (int j = 0; j < N; j++) xv[j] = k % 7 == 0 ? -128 : int'($urandom_range(255, 0)) - 128;
      send_job(1);
    end
    drain("random_drain");
    rand_rdy = 0;
    m_ready = 1;
    repeat (3) @(posedge clk);
    #1;
    check("final_busy", int'(busy), 0);
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end
endmodule
